// File: rtl/wb_uart_loader.sv
// wb_uart_loader: UART 8N1 boot loader issuing single Wishbone writes; define WB_UART_LOADER_CHECKSUM_EN for a trailing XOR checksum byte
module wb_uart_loader #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         TIMEOUT_BITS = 64,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        uart_rx_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        error_o
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_END = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_END = BW'(CLKS_PER_BIT / 2 - 1);
    localparam int TMO = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_END = TW'(TMO);
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ABORT} state_t;
    rx_t           rx_st_q;
    logic [2:0]    sync_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q, buf_q;
    logic          full_q, frame_err_q, overrun_q;
    state_t        state_q;
    logic [1:0]    bcnt_q;
    logic [31:0]   addr_q, word_q;
    logic [15:0]   len_q;
    logic [TW-1:0] tmo_q;
    logic          cyc_q, hold_q, done_q, err_q;
    logic          take, counting;
    always_comb begin
        counting = state_q inside {S_ADDR, S_LEN, S_DATA, S_CSUM};
        take = full_q && (counting || state_q == S_IDLE);
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q <= 3'b111;
            rx_st_q <= R_IDLE;
            baud_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            buf_q <= '0;
            full_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], uart_rx_i};
            frame_err_q <= 1'b0;
            overrun_q <= 1'b0;
            baud_q <= baud_q + BW'(1);
            if (take) full_q <= 1'b0;
            case (rx_st_q)
                R_IDLE: begin
                    baud_q <= '0;
                    if (sync_q[2] && !sync_q[1]) rx_st_q <= R_START;
                end
                R_START: if (baud_q == HALF_END) begin
                    baud_q <= '0;
                    bit_q <= '0;
                    rx_st_q <= sync_q[1] ? R_IDLE : R_DATA;
                end
                R_DATA: if (baud_q == BIT_END) begin
                    baud_q <= '0;
                    shift_q <= {sync_q[1], shift_q[7:1]};
                    bit_q <= bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_st_q <= R_STOP;
                end
                default: if (baud_q == BIT_END) begin
                    rx_st_q <= R_IDLE;
                    if (!sync_q[1]) frame_err_q <= 1'b1;
                    else if (full_q && !take) overrun_q <= 1'b1;
                    else begin
                        buf_q <= shift_q;
                        full_q <= 1'b1;
                    end
                end
            endcase
        end
    end
`ifdef WB_UART_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CSUM;
    logic [7:0] csum_q;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_q == S_IDLE) csum_q <= 8'h00;
        else if (take) csum_q <= csum_q ^ buf_q;
    end
`else
    localparam state_t S_END = S_DONE;
`endif
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            bcnt_q <= '0;
            addr_q <= '0;
            word_q <= '0;
            len_q <= '0;
            tmo_q <= '0;
            cyc_q <= 1'b0;
            hold_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tmo_q <= (counting && !take) ? tmo_q + TW'(1) : '0;
            if (frame_err_q || overrun_q) err_q <= 1'b1;
            case (state_q)
                S_IDLE: if (take && buf_q == SYNC_BYTE) begin
                    state_q <= S_ADDR;
                    hold_q <= 1'b1;
                    err_q <= 1'b0;
                    bcnt_q <= '0;
                end
                S_ADDR: if (take) begin
                    addr_q <= {addr_q[23:0], buf_q};
                    bcnt_q <= bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        addr_q <= {addr_q[23:0], buf_q[7:2], 2'b00};
                        state_q <= S_LEN;
                    end
                end
                S_LEN: if (take) begin
                    len_q <= {len_q[7:0], buf_q};
                    bcnt_q <= bcnt_q[0] ? 2'd0 : 2'd1;
                    if (bcnt_q[0]) state_q <= ({len_q[7:0], buf_q} == 16'd0) ? S_END : S_DATA;
                end
                S_DATA: if (take) begin
                    word_q <= {word_q[23:0], buf_q};
                    bcnt_q <= bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_q <= S_WRITE;
                        cyc_q <= 1'b1;
                    end
                end
                // cyc low inside WRITE is the one-cycle gap before a retried attempt
                S_WRITE: if (!cyc_q) cyc_q <= 1'b1;
                else if (wb_err_i) begin
                    cyc_q <= 1'b0;
                    err_q <= 1'b1;
                    state_q <= S_ABORT;
                end else if (wb_ack_i) begin
                    cyc_q <= 1'b0;
                    addr_q <= addr_q + 32'd4;
                    len_q <= len_q - 16'd1;
                    state_q <= (len_q == 16'd1) ? S_END : S_DATA;
                end else if (wb_rty_i) cyc_q <= 1'b0;
`ifdef WB_UART_LOADER_CHECKSUM_EN
                S_CSUM: if (take) begin
                    state_q <= (buf_q == csum_q) ? S_DONE : S_ABORT;
                    if (buf_q != csum_q) err_q <= 1'b1;
                end
`endif
                S_DONE: begin
                    done_q <= 1'b1;
                    hold_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ABORT: begin
                    hold_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if ((counting && tmo_q == TMO_END) || (overrun_q && state_q != S_IDLE)) begin
                state_q <= S_ABORT;
                cyc_q <= 1'b0;
                err_q <= 1'b1;
            end
        end
    end
    assign wb_adr_o = addr_q;
    assign wb_dat_o = word_q;
    assign wb_sel_o = 4'hF;
    assign wb_we_o = cyc_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;
    assign cpu_hold_o = hold_q;
    assign done_o = done_q;
    assign error_o = err_q;
endmodule

// File: tb/tb_wb_uart_loader.sv
// tb_wb_uart_loader: directed bench for wb_uart_loader with a Wishbone slave responder and UART byte driver
module tb_wb_uart_loader;
    localparam int CPB = 8;
    logic        clk = 1'b0, rst = 1'b1, rx = 1'b1;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic        hold, done, error;
    int          total = 0, bad = 0, cycle = 0;
    int          rty_left = 0, done_cnt = 0, attr_bad = 0, bad_idx = -1;
    bit          err_mode = 1'b0, hang = 1'b0;
    logic [31:0] wr_adr[$], wr_dat[$], at_adr[$], at_dat[$];
    int          at_cyc[$];
    logic [7:0]  pkt[$];
`ifdef WB_UART_LOADER_CHECKSUM_EN
    bit          csum_bad = 1'b0;
`endif

    wb_uart_loader #(.CLKS_PER_BIT(CPB)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .uart_rx_i(rx),
        .wb_adr_o(adr), .wb_dat_o(dat), .wb_sel_o(sel), .wb_we_o(we),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_cti_o(cti), .wb_bte_o(bte),
        .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty),
        .cpu_hold_o(hold), .done_o(done), .error_o(error)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    initial forever begin
        @(negedge clk);
        ack = 1'b0;
        err = 1'b0;
        rty = 1'b0;
        if (done) done_cnt++;
        if (cyc && stb && !hang) begin
            at_adr.push_back(adr);
            at_dat.push_back(dat);
            at_cyc.push_back(cycle);
            if (!hold || !we || sel != 4'hF || cti != 3'b000 || bte != 2'b00) attr_bad++;
            if (rty_left > 0) begin
                rty = 1'b1;
                rty_left--;
            end else if (err_mode) err = 1'b1;
            else begin
                ack = 1'b1;
                wr_adr.push_back(adr);
                wr_dat.push_back(dat);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        wr_adr.delete();
        wr_dat.delete();
        at_adr.delete();
        at_dat.delete();
        at_cyc.delete();
        done_cnt = 0;
        attr_bad = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_pkt();
`ifdef WB_UART_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
`endif
        foreach (pkt[i]) begin
            send_byte(pkt[i], i != bad_idx);
`ifdef WB_UART_LOADER_CHECKSUM_EN
            if (i > 0 && i != bad_idx) x ^= pkt[i];
`endif
        end
`ifdef WB_UART_LOADER_CHECKSUM_EN
        send_byte(csum_bad ? ~x : x, 1'b1);
`endif
        repeat (20) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst cyc", cyc, 0);
        check("rst stb", stb, 0);
        check("rst we", we, 0);
        check("rst adr", adr, 0);
        check("rst dat", dat, 0);
        check("rst hold", hold, 0);
        check("rst done", done, 0);
        check("rst error", error, 0);
        @(posedge clk);
        rst = 1'b0;

        clear();
        pkt = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02,
                8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        send_pkt();
        check("t1 nwr", wr_adr.size(), 2);
        check("t1 adr0", wr_adr[0], 32'h0000_1000);
        check("t1 dat0", wr_dat[0], 32'hDEAD_BEEF);
        check("t1 adr1", wr_adr[1], 32'h0000_1004);
        check("t1 dat1", wr_dat[1], 32'h0123_4567);
        check("t1 attr", attr_bad, 0);
        check("t1 done", done_cnt, 1);
        check("t1 hold", hold, 0);
        check("t1 error", error, 0);

        clear();
        pkt = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h01,
                8'h11, 8'h22, 8'h33, 8'h44};
        send_pkt();
        check("t2 nwr", wr_adr.size(), 1);
        check("t2 adr", wr_adr[0], 32'h0000_0000);
        check("t2 dat", wr_dat[0], 32'h1122_3344);
        check("t2 done", done_cnt, 1);

        clear();
        rty_left = 2;
        pkt = '{8'hA5, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h01,
                8'hCA, 8'hFE, 8'hF0, 8'h0D};
        send_pkt();
        check("t3 attempts", at_adr.size(), 3);
        check("t3 adr2", at_adr[2], 32'h0000_2000);
        check("t3 dat1", at_dat[1], 32'hCAFE_F00D);
        check("t3 gap1", at_cyc[1] - at_cyc[0], 2);
        check("t3 gap2", at_cyc[2] - at_cyc[1], 2);
        check("t3 nwr", wr_adr.size(), 1);
        check("t3 done", done_cnt, 1);

        clear();
        err_mode = 1'b1;
        pkt = '{8'hA5, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h02,
                8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
        send_pkt();
        err_mode = 1'b0;
        check("t4 attempts", at_adr.size(), 1);
        check("t4 nwr", wr_adr.size(), 0);
        check("t4 error", error, 1);
        check("t4 done", done_cnt, 0);
        check("t4 hold", hold, 0);

        clear();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h40, 1'b1);
        @(negedge clk);
        check("t5 hold", hold, 1);
        check("t5 errclr", error, 0);
        repeat (400) @(posedge clk);
        @(negedge clk);
        check("t5 early hold", hold, 1);
        check("t5 early err", error, 0);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("t5 tmo hold", hold, 0);
        check("t5 tmo err", error, 1);
        check("t5 done", done_cnt, 0);
        pkt = '{8'hA5, 8'h00, 8'h00, 8'h50, 8'h00, 8'h00, 8'h01,
                8'hAB, 8'hCD, 8'hEF, 8'h01};
        send_pkt();
        check("t5b error", error, 0);
        check("t5b nwr", wr_adr.size(), 1);
        check("t5b adr", wr_adr[0], 32'h0000_5000);
        check("t5b dat", wr_dat[0], 32'hABCD_EF01);
        check("t5b done", done_cnt, 1);

        clear();
        bad_idx = 5;
        pkt = '{8'hA5, 8'h00, 8'h00, 8'h60, 8'h00, 8'h77, 8'h00, 8'h01,
                8'h11, 8'h22, 8'h33, 8'h44};
        send_pkt();
        bad_idx = -1;
        check("t6 error", error, 1);
        check("t6 nwr", wr_adr.size(), 1);
        check("t6 adr", wr_adr[0], 32'h0000_6000);
        check("t6 dat", wr_dat[0], 32'h1122_3344);
        check("t6 done", done_cnt, 1);

`ifdef WB_UART_LOADER_CHECKSUM_EN
        clear();
        csum_bad = 1'b1;
        pkt = '{8'hA5, 8'h00, 8'h00, 8'h70, 8'h00, 8'h00, 8'h01,
                8'h12, 8'h34, 8'h56, 8'h78};
        send_pkt();
        csum_bad = 1'b0;
        check("t7 nwr", wr_adr.size(), 1);
        check("t7 error", error, 1);
        check("t7 done", done_cnt, 0);
        clear();
        send_pkt();
        check("t7b error", error, 0);
        check("t7b done", done_cnt, 1);
`endif

        clear();
        hang = 1'b1;
        pkt = '{8'hA5, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h01,
                8'h00, 8'h00, 8'h00, 8'h01};
        send_pkt();
        check("t8 cyc held", cyc, 1);
        check("t8 hold", hold, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t8 rst cyc", cyc, 0);
        check("t8 rst stb", stb, 0);
        check("t8 rst hold", hold, 0);
        rst = 1'b0;
        hang = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
